// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the HC-SR04 style ultrasonic ranger.
package ultrasonic_pkg;

  // Counter widths (us counter covers the 60000 us hold-off)
  localparam int unsigned US_CNT_W  = 17;
  localparam int unsigned SUB_CNT_W = 6;
  localparam int unsigned CM_CNT_W  = 9;
  localparam int unsigned ERR_W     = 2;
  localparam int unsigned STATE_W   = 3;

  // Default timing, all in microsecond ticks
  localparam int unsigned TRIG_US_DEF         = 10;
  localparam int unsigned CM_DIV_US_DEF       = 58;
  localparam int unsigned ECHO_TIMEOUT_US_DEF = 30000;
  localparam int unsigned MAX_CM_DEF          = 400;
  localparam int unsigned HOLDOFF_US_DEF      = 60000;

  // Measurement FSM states
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_TRIG      = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_RISE = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEASURE   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLDOFF   = 3'd4;

  // Result status codes
  typedef enum logic [ERR_W-1:0] {
    ERR_OK        = 2'd0,
    ERR_NO_ECHO   = 2'd1,
    ERR_OVERRANGE = 2'd2
  } err_e;

  // Measurement result payload presented to the display logic
  typedef struct packed {
    logic [CM_CNT_W-1:0] distance_cm;
    err_e                err;
  } result_t;

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Request/result bus between the ranger and its host (display/FND logic).
interface ultrasonic_ranger_if;
  import ultrasonic_pkg::*;

  logic                start;
  logic                busy;
  logic                valid;
  logic [CM_CNT_W-1:0] distance_cm;
  logic [ERR_W-1:0]    err;

  modport master (output start, input busy, valid, distance_cm, err);
  modport slave  (input start, output busy, valid, distance_cm, err);

endinterface

// File: rtl/echo_sync_edge.sv
// Two-flop synchronizer for the raw sensor echo with registered rise/fall pulses.
module echo_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Synchronize echo, then register single-cycle edge pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1   <= echo;
      sync2   <= sync1;
      sync2_d <= sync2;
      rise    <= sync2 & ~sync2_d;
      fall    <= ~sync2 & sync2_d;
    end
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: issues trigger, times echo in us ticks, reports cm.
// Optional build macro ULTRASONIC_AUTO_TRIG_EN: measure continuously without start.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_US         = TRIG_US_DEF,
  parameter int unsigned CM_DIV_US       = CM_DIV_US_DEF,
  parameter int unsigned ECHO_TIMEOUT_US = ECHO_TIMEOUT_US_DEF,
  parameter int unsigned MAX_CM          = MAX_CM_DEF,
  parameter int unsigned HOLDOFF_US      = HOLDOFF_US_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_usec,
  input  logic               echo,
  output logic               trig,
  ultrasonic_ranger_if.slave bus
);

  localparam logic [US_CNT_W-1:0]  TRIG_LAST    = US_CNT_W'(TRIG_US);
  localparam logic [US_CNT_W-1:0]  TIMEOUT_LAST = US_CNT_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [US_CNT_W-1:0]  HOLDOFF_LAST = US_CNT_W'(HOLDOFF_US - 1);
  localparam logic [SUB_CNT_W-1:0] SUB_LAST     = SUB_CNT_W'(CM_DIV_US - 1);
  localparam logic [CM_CNT_W-1:0]  CM_SAT       = CM_CNT_W'(MAX_CM);

  logic                 echo_rise;
  logic                 echo_fall;
  logic                 go_c;

  logic [STATE_W-1:0]   state;
  logic [STATE_W-1:0]   state_nx;
  logic [US_CNT_W-1:0]  us_cnt;
  logic [US_CNT_W-1:0]  us_cnt_nx;
  logic [SUB_CNT_W-1:0] sub_cnt;
  logic [SUB_CNT_W-1:0] sub_cnt_nx;
  logic [CM_CNT_W-1:0]  cm_cnt;
  logic [CM_CNT_W-1:0]  cm_cnt_nx;
  result_t              result;
  result_t              result_nx;
  logic                 valid_nx;
  logic                 valid;
  logic                 busy;

  echo_sync_edge u_echo_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .echo    (echo),
    .rise    (echo_rise),
    .fall    (echo_fall)
  );

`ifdef ULTRASONIC_AUTO_TRIG_EN
  // Free-running: leave IDLE as soon as it is reached
  assign go_c = 1'b1;
`else
  // Host-requested: start is only looked at while idle
  assign go_c = bus.start;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      us_cnt  <= '0;
      sub_cnt <= '0;
      cm_cnt  <= '0;
      result  <= '{distance_cm: '0, err: ERR_OK};
      valid   <= 1'b0;
      trig    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      us_cnt  <= us_cnt_nx;
      sub_cnt <= sub_cnt_nx;
      cm_cnt  <= cm_cnt_nx;
      result  <= result_nx;
      valid   <= valid_nx;
      trig    <= (state_nx == ST_TRIG);
      busy    <= (state_nx != ST_IDLE);
    end
  end

  // Next-state, counter and result logic
  always_comb begin
    state_nx   = state;
    us_cnt_nx  = us_cnt;
    sub_cnt_nx = sub_cnt;
    cm_cnt_nx  = cm_cnt;
    result_nx  = result;
    valid_nx   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (go_c) begin
          state_nx   = ST_TRIG;
          us_cnt_nx  = '0;
          sub_cnt_nx = '0;
          cm_cnt_nx  = '0;
        end
      end

      // Trigger stays high until the (TRIG_US+1)th tick, giving 10..11 us
      ST_TRIG: begin
        if (clk_usec) begin
          if (us_cnt == TRIG_LAST) begin
            state_nx  = ST_WAIT_RISE;
            us_cnt_nx = '0;
          end else begin
            us_cnt_nx = us_cnt + US_CNT_W'(1);
          end
        end
      end

      // A level already high on entry produces no rise pulse, so it is ignored
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_nx   = ST_MEASURE;
          us_cnt_nx  = '0;
          sub_cnt_nx = '0;
          cm_cnt_nx  = '0;
        end else if (clk_usec) begin
          if (us_cnt == TIMEOUT_LAST) begin
            state_nx      = ST_HOLDOFF;
            us_cnt_nx     = '0;
            result_nx.err = ERR_NO_ECHO;
            valid_nx      = 1'b1;
          end else begin
            us_cnt_nx = us_cnt + US_CNT_W'(1);
          end
        end
      end

      // Priority: saturation, then falling edge, then tick
      ST_MEASURE: begin
        if (cm_cnt >= CM_SAT) begin
          state_nx              = ST_HOLDOFF;
          us_cnt_nx             = '0;
          result_nx.distance_cm = CM_SAT;
          result_nx.err         = ERR_OVERRANGE;
          valid_nx              = 1'b1;
        end else if (echo_fall) begin
          state_nx              = ST_HOLDOFF;
          us_cnt_nx             = '0;
          result_nx.distance_cm = cm_cnt;
          result_nx.err         = ERR_OK;
          valid_nx              = 1'b1;
        end else if (clk_usec) begin
          if (sub_cnt == SUB_LAST) begin
            sub_cnt_nx = '0;
            cm_cnt_nx  = cm_cnt + CM_CNT_W'(1);
          end else begin
            sub_cnt_nx = sub_cnt + SUB_CNT_W'(1);
          end
        end
      end

      // Sensor recovery time before another trigger is allowed
      ST_HOLDOFF: begin
        if (clk_usec) begin
          if (us_cnt == HOLDOFF_LAST) begin
            state_nx  = ST_IDLE;
            us_cnt_nx = '0;
          end else begin
            us_cnt_nx = us_cnt + US_CNT_W'(1);
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Result bus driven straight from registers
  assign bus.valid       = valid;
  assign bus.busy        = busy;
  assign bus.distance_cm = result.distance_cm;
  assign bus.err         = result.err;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with shortened timing parameters.
module tb_ultrasonic_ranger;

  localparam int unsigned P_TRIG   = 10;
  localparam int unsigned P_DIV    = 8;
  localparam int unsigned P_TMO    = 200;
  localparam int unsigned P_MAX    = 30;
  localparam int unsigned P_HOLD   = 50;
  localparam int          TICK_DIV = 4;
  localparam int          SAT_W    = P_MAX * P_DIV;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic clk_usec = 1'b0;
  logic echo     = 1'b0;
  logic trig;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int trig_rises = 0;
  int tick_div   = 0;
  int model_dist = 0;
  logic trig_d   = 1'b0;

  ultrasonic_ranger_if bus_if ();

  ultrasonic_ranger #(
    .TRIG_US         (P_TRIG),
    .CM_DIV_US       (P_DIV),
    .ECHO_TIMEOUT_US (P_TMO),
    .MAX_CM          (P_MAX),
    .HOLDOFF_US      (P_HOLD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_usec (clk_usec),
    .echo     (echo),
    .trig     (trig),
    .bus      (bus_if)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle us tick every TICK_DIV clocks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      clk_usec = (tick_div == 0);
      tick_div = (tick_div + 1) % TICK_DIV;
    end
  end

  // Count trigger pulses issued by the DUT
  always @(negedge clk) begin
    if (trig === 1'b1 && trig_d === 1'b0) trig_rises = trig_rises + 1;
    trig_d = trig;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One measurement: w is echo width in us ticks
  task automatic run_meas(input int w, input bit no_echo, input bit poke);
    int n;
    int k;
    int ticks;
    int limit;
    int wait_ticks;
    int ho;
    int exp_rises;
    int r_cyc;
    int f_cyc;
    int v_cyc;
    int exp_dist;
    int exp_err;
    bit got_valid;
    bit echo_at_valid;
    bit poked;
    bit clr_start;
    logic [8:0] v_dist;
    logic [1:0] v_err;

    n = 0; k = 0; ticks = 0; wait_ticks = 0; ho = 0;
    r_cyc = 0; f_cyc = 0; v_cyc = 0;
    got_valid = 1'b0; echo_at_valid = 1'b0; poked = 1'b0; clr_start = 1'b0;
    v_dist = '0; v_err = '0;

    // Reference: pulse width in us divided into cm, saturating, timeout keeps distance
    if (no_echo) begin
      exp_err  = 1;
      exp_dist = model_dist;
    end else if (w >= SAT_W) begin
      exp_err  = 2;
      exp_dist = P_MAX;
    end else begin
      exp_err  = 0;
      exp_dist = w / P_DIV;
    end
    limit     = TICK_DIV * (w + P_TMO + P_HOLD + 40);
    exp_rises = trig_rises + 1;

    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    check("trig_latency", 32'(trig), 32'(1));
    check("busy_latency", 32'(bus_if.busy), 32'(1));

    while (trig === 1'b1 && n < TICK_DIV * (P_TRIG + 4)) begin
      @(negedge clk);
      if (trig === 1'b1 && clk_usec === 1'b1) ticks++;
      n++;
    end
    check("trig_ticks", 32'(ticks), 32'(P_TRIG + 1));

    fork
      begin
        if (!no_echo) begin
          while (clk_usec !== 1'b1 && k < 4 * TICK_DIV) begin
            @(negedge clk);
            k++;
          end
          @(posedge clk);
          @(posedge clk);
          #1 echo = 1'b1;
          r_cyc = cyc;
          for (int i = 0; i < TICK_DIV * w; i++) begin
            @(posedge clk);
            #1;
            if (poke) bus_if.start = (i == (TICK_DIV * w) / 2);
          end
          echo  = 1'b0;
          f_cyc = cyc;
          if (poke) bus_if.start = 1'b0;
        end
      end
      begin
        n = 0;
        while (!got_valid && n < limit) begin
          @(negedge clk);
          n++;
          if (bus_if.valid === 1'b1) begin
            got_valid     = 1'b1;
            v_cyc         = cyc;
            v_dist        = bus_if.distance_cm;
            v_err         = bus_if.err;
            echo_at_valid = echo;
            ho            = (clk_usec === 1'b1) ? 1 : 0;
          end else if (clk_usec === 1'b1) begin
            wait_ticks++;
          end
        end
        if (got_valid) begin
          n = 0;
          while (n < limit) begin
            @(negedge clk);
            n++;
            if (clr_start) begin
              bus_if.start = 1'b0;
              clr_start    = 1'b0;
            end
            if (bus_if.busy !== 1'b1) break;
            if (clk_usec === 1'b1) ho++;
            if (poke && !poked && ho == 3) begin
              bus_if.start = 1'b1;
              poked        = 1'b1;
              clr_start    = 1'b1;
            end
          end
        end
      end
    join
    bus_if.start = 1'b0;

    if (!got_valid) begin
      check("valid_seen", 32'(0), 32'(1));
    end else begin
      check("distance_cm", 32'(v_dist), 32'(exp_dist));
      check("err", 32'(v_err), 32'(exp_err));
      check("holdoff_ticks", 32'(ho), 32'(P_HOLD));
      if (no_echo) check("timeout_ticks", 32'(wait_ticks), 32'(P_TMO));
      if (exp_err == 0) check("valid_latency", 32'(v_cyc - f_cyc), 32'(4));
      if (exp_err == 2) check("ovr_time", 32'(v_cyc - r_cyc), 32'(TICK_DIV * SAT_W + 4));
      if (exp_err == 2 && w >= SAT_W + 2) check("ovr_before_fall", 32'(echo_at_valid), 32'(1));
    end
    check("busy_after", 32'(bus_if.busy), 32'(0));
    repeat (3 * TICK_DIV) @(posedge clk);
    #1;
    check("trig_count", 32'(trig_rises), 32'(exp_rises));
    model_dist = exp_dist;
  endtask

  initial begin
    int w;
    int exp_rises;
    bit ne;
    bit pk;

    bus_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_trig", 32'(trig), 32'(0));
    check("rst_dist", 32'(bus_if.distance_cm), 32'(0));
    check("rst_valid", 32'(bus_if.valid), 32'(0));
    check("rst_err", 32'(bus_if.err), 32'(0));
    check("rst_busy", 32'(bus_if.busy), 32'(0));
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_without_start", 32'(bus_if.busy), 32'(0));

    // Directed cases
    run_meas(5 * P_DIV, 1'b0, 1'b0);
    run_meas(5 * P_DIV + P_DIV - 1, 1'b0, 1'b0);
    run_meas(P_DIV - 1, 1'b0, 1'b0);
    run_meas(0, 1'b1, 1'b0);
    run_meas(SAT_W - 1, 1'b0, 1'b0);
    run_meas(SAT_W, 1'b0, 1'b0);
    run_meas(SAT_W + 20, 1'b0, 1'b0);
    run_meas(10 * P_DIV, 1'b0, 1'b1);

    // Randomized measurements
    for (int t = 0; t < 14; t++) begin
      ne = ($urandom_range(0, 5) == 0);
      w  = $urandom_range(1, SAT_W + 20);
      pk = (w < SAT_W) && ($urandom_range(0, 1) == 1);
      run_meas(w, ne, pk);
    end

    // Asynchronous reset while the trigger is high
    exp_rises = trig_rises + 1;
    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("trig_before_reset", 32'(trig), 32'(1));
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_trig", 32'(trig), 32'(0));
    check("rst_async_busy", 32'(bus_if.busy), 32'(0));
    check("rst_async_dist", 32'(bus_if.distance_cm), 32'(0));
    check("rst_async_err", 32'(bus_if.err), 32'(0));
    check("rst_async_valid", 32'(bus_if.valid), 32'(0));
    model_dist = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(bus_if.busy), 32'(0));
    check("post_reset_trig_count", 32'(trig_rises), 32'(exp_rises));
    run_meas(2 * P_DIV + 3, 1'b0, 1'b0);
    run_meas(0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
